// File: rtl/gate_truth_tester.sv
// Walks a two-input gate through all four {A,B} vectors, samples Z after a settle
// interval and compares it with the TRUTH table; reports pass, error count and first failing vector.
module gate_truth_tester #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] TRUTH         = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Z_IN,
  output logic       A_OUT,
  output logic       B_OUT,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [1:0] ff_q, ff_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      ff_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    case (state_q)
      IDLE, DONE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d = APPLY;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          err_d   = 3'd0;
          ff_d    = 2'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (Z_IN != TRUTH[vec_q]) begin
          err_d = err_q + 3'd1;
          if (err_q == 3'd0) ff_d = vec_q;
        end
        if (vec_q == 2'd3) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          // Next vector goes out on the same edge that samples the current one.
          vec_d   = vec_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = APPLY;
          a_d     = vec_d[1];
          b_d     = vec_d[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign A_OUT      = a_q;
  assign B_OUT      = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: doc/gate_truth_tester.md
Name: gate_truth_tester

Overview:
- Sequential stimulus generator and response checker for a two-input combinational gate under test.
- Drives all four input combinations onto the gate's A/B inputs and waits a settle interval after each.
- Samples the gate's Z output and compares it against an expected truth table.
- Reports pass/fail, an error count and the first failing vector. Sits beside any two-input gate module in the simulation and FPGA self-check harness.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before Z is sampled; legal range 1..15.
- TRUTH, 4'b1000, expected Z per vector index i = {A,B}; bit i is the expected output (4'b1000 = AND, 4'b1110 = OR).

Ports:
- clk  input  1  single system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a test run
- Z_IN  input  1  output of gate under test
- A_OUT  output  1  drives gate input A
- B_OUT  output  1  drives gate input B
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until next accepted start
- pass  output  1  valid while done=1; 1 iff err_count==0
- err_count  output  3  number of mismatching vectors, 0..4
- first_fail  output  2  index {A,B} of first mismatching vector; 0 if none

Behaviour:
- Reset (rst_n low, async): state IDLE; vec=0, cnt=0; A_OUT=B_OUT=0; busy=done=pass=0; err_count=0; first_fail=0. Reset mid-run aborts immediately; done does not assert.
- States: IDLE, APPLY, SAMPLE, DONE. All outputs are registered.
- IDLE/DONE, start=1:
  - clear err_count and first_fail; vec=0, cnt=0; go to APPLY.
  - done and pass drop on the same edge; busy=1.
- IDLE/DONE, start=0: hold. A_OUT=B_OUT=0 in both states.
- APPLY:
  - A_OUT=vec[1], B_OUT=vec[0].
  - cnt increments each cycle. When cnt==SETTLE_CYCLES-1, next state is SAMPLE.
  - Vector held for SETTLE_CYCLES cycles before the sample edge.
- SAMPLE: A/B still held; Z_IN registered on this edge and compared with TRUTH[vec].
  - Mismatch: err_count+1. If err_count was 0, first_fail=vec.
  - vec==3: go to DONE; busy=0, done=1, pass=(final err_count==0).
  - Otherwise: vec+1, cnt=0, back to APPLY.
- Timing: each vector takes SETTLE_CYCLES+1 cycles. done rises 4*(SETTLE_CYCLES+1) edges after the edge that samples start; with defaults, 12 cycles.
- start while busy=1 is ignored, with no restart and no effect on counts.
- err_count cannot exceed 4; no wrap possible.
- The vector counter wraps nowhere; the run always ends at vec=3.
- Z_IN is only sampled in SAMPLE; glitches during APPLY are ignored.

Test Plan:
- AND gate connected, defaults, start pulse → A/B sequence 00,01,10,11 each held 3 cycles; done=1 exactly 12 cycles after start; pass=1, err_count=0, first_fail=0.
- Z_IN tied 0, TRUTH=4'b1000 → err_count=1, first_fail=2'b11, pass=0.
- Z_IN tied 1 → err_count=3, first_fail=2'b00, pass=0.
- OR gate connected, TRUTH=4'b1000 → err_count=2, first_fail=2'b01. Rerun with TRUTH=4'b1110 → pass=1.
- Second start pulse at cycle 5 of a run → ignored; done still at cycle 12 with unchanged results. start in DONE clears done/pass and starts a new run.
- rst_n low at cycle 7 of a run → all outputs 0 asynchronously; after release, no done until a new start. Then SETTLE_CYCLES=1: done at 8 cycles.
